// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and FSM state types for the on-chip memory responder.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] SIZE_16B    = 3'b100;

  // Byte offset of the word index inside an address (16-byte beats).
  localparam int unsigned BEAT_OFFSET = 4;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_t;

  // Only full-width INCR/FIXED bursts map onto the RAM; everything else
  // is answered with SLVERR and never touches memory.
  function automatic logic burst_supported(input logic [1:0] burst,
                                           input logic [2:0] size);
    return ((burst == BURST_INCR) || (burst == BURST_FIXED)) && (size == SIZE_16B);
  endfunction

endpackage

// File: rtl/sdp_ram_be.sv
// Simple-dual-port RAM, DEPTH x DATA_W, byte-enable write port, registered read port.
// Latency: read data valid the cycle after re; write visible to reads issued the next cycle.
// Backpressure: none; rdata holds its value while re is low (read-first on same-word collision).
// Ports: clk; we/waddr/wbe/wdata write port; re/raddr read request; rdata registered read data.
module sdp_ram_be #(
  parameter  int DATA_W = 128,
  parameter  int DEPTH  = 1024,
  localparam int IDX_W  = $clog2(DEPTH),
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [BE_W-1:0]   wbe,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write and read share one process so a collision returns the old word.
  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wbe[b]) begin
          mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/axi_mem_rsp.sv
// AXI4 responder backed by an on-chip SDP RAM; independent write (AW/W/B) and read (AR/R) engines.
// Latency: B one cycle after WLAST handshake; first R beat two cycles after the AR handshake, then 1 beat/cycle.
// Backpressure: W accepted only after AW; B and R outputs hold while VALID && !READY; one burst in flight per engine.
// Ports: clk, rst (sync, active-high); S_AXI_AW*/W*/B* write channel; S_AXI_AR*/R* read channel.
module axi_mem_rsp
  import axi_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 29,
  parameter int ID_W   = 4,
  parameter int DEPTH  = 1024
) (
  input  logic                clk,
  input  logic                rst,
  // write address
  input  logic [ADDR_W-1:0]   S_AXI_AWADDR,
  input  logic [1:0]          S_AXI_AWBURST,
  input  logic [ID_W-1:0]     S_AXI_AWID,
  input  logic [7:0]          S_AXI_AWLEN,
  input  logic [2:0]          S_AXI_AWSIZE,
  input  logic                S_AXI_AWVALID,
  output logic                S_AXI_AWREADY,
  // write data
  input  logic [DATA_W-1:0]   S_AXI_WDATA,
  input  logic [DATA_W/8-1:0] S_AXI_WSTRB,
  input  logic                S_AXI_WLAST,
  input  logic                S_AXI_WVALID,
  output logic                S_AXI_WREADY,
  // write response
  output logic [ID_W-1:0]     S_AXI_BID,
  output logic [1:0]          S_AXI_BRESP,
  output logic                S_AXI_BVALID,
  input  logic                S_AXI_BREADY,
  // read address
  input  logic [ADDR_W-1:0]   S_AXI_ARADDR,
  input  logic [1:0]          S_AXI_ARBURST,
  input  logic [ID_W-1:0]     S_AXI_ARID,
  input  logic [7:0]          S_AXI_ARLEN,
  input  logic [2:0]          S_AXI_ARSIZE,
  input  logic                S_AXI_ARVALID,
  output logic                S_AXI_ARREADY,
  // read data
  output logic [DATA_W-1:0]   S_AXI_RDATA,
  output logic [ID_W-1:0]     S_AXI_RID,
  output logic [1:0]          S_AXI_RRESP,
  output logic                S_AXI_RLAST,
  output logic                S_AXI_RVALID,
  input  logic                S_AXI_RREADY
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int STRB_W = DATA_W / 8;

  // Only the word-index bits of the addresses matter; the rest alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{S_AXI_AWADDR, S_AXI_ARADDR};

  // ---------------------------------------------------------------------
  // Write engine
  // ---------------------------------------------------------------------
  w_state_t          w_state, w_state_nxt;
  logic              aw_rdy, w_rdy, b_vld;
  logic [ID_W-1:0]   w_id;
  logic [IDX_W-1:0]  w_idx;
  logic [7:0]        w_len;
  logic [7:0]        w_cnt;
  logic              w_fixed;
  logic              w_ok;
  logic              w_err;
  logic              aw_hs, w_hs;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
    end else begin
      w_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = w_state;
    aw_rdy      = 1'b0;
    w_rdy       = 1'b0;
    b_vld       = 1'b0;
    case (w_state)
      W_IDLE: begin
        aw_rdy = 1'b1;
        if (S_AXI_AWVALID) begin
          w_state_nxt = W_DATA;
        end
      end
      W_DATA: begin
        w_rdy = 1'b1;
        // The burst ends on WLAST whatever the beat count says.
        if (S_AXI_WVALID && S_AXI_WLAST) begin
          w_state_nxt = W_RESP;
        end
      end
      W_RESP: begin
        b_vld = 1'b1;
        if (S_AXI_BREADY) begin
          w_state_nxt = W_IDLE;
        end
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  assign aw_hs = aw_rdy && S_AXI_AWVALID;
  assign w_hs  = w_rdy && S_AXI_WVALID;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_id    <= '0;
      w_idx   <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_fixed <= 1'b0;
      w_ok    <= 1'b0;
      w_err   <= 1'b0;
    end else if (aw_hs) begin
      w_id    <= S_AXI_AWID;
      w_idx   <= S_AXI_AWADDR[BEAT_OFFSET +: IDX_W];
      w_len   <= S_AXI_AWLEN;
      w_cnt   <= '0;
      w_fixed <= (S_AXI_AWBURST == BURST_FIXED);
      w_ok    <= burst_supported(S_AXI_AWBURST, S_AXI_AWSIZE);
      w_err   <= 1'b0;
    end else if (w_hs) begin
      w_cnt <= w_cnt + 8'd1;
      if (!w_fixed) begin
        w_idx <= w_idx + IDX_W'(1);
      end
      // WLAST must coincide exactly with beat len; early or missing is an error.
      if (S_AXI_WLAST != (w_cnt == w_len)) begin
        w_err <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read engine
  // ---------------------------------------------------------------------
  r_state_t          r_state, r_state_nxt;
  logic              ar_rdy;
  logic              rd_en;
  logic              ar_hs;
  logic [ID_W-1:0]   r_id;
  logic [IDX_W-1:0]  r_idx;
  logic [8:0]        r_left;   // beats still to be read from RAM
  logic              r_fixed;
  logic              r_ok;
  logic              r_vld;
  logic              r_last;
  logic              r_zero;   // beat belongs to an unsupported burst

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
    end else begin
      r_state <= r_state_nxt;
    end
  end

  always_comb begin
    r_state_nxt = r_state;
    ar_rdy      = 1'b0;
    rd_en       = 1'b0;
    case (r_state)
      R_IDLE: begin
        ar_rdy = 1'b1;
        if (S_AXI_ARVALID) begin
          r_state_nxt = R_DATA;
        end
      end
      R_DATA: begin
        // Refill the output register whenever it is empty or being drained.
        rd_en = (r_left != 9'd0) && (!r_vld || S_AXI_RREADY);
        if (r_vld && S_AXI_RREADY && r_last) begin
          r_state_nxt = R_IDLE;
        end
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  assign ar_hs = ar_rdy && S_AXI_ARVALID;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_id    <= '0;
      r_idx   <= '0;
      r_left  <= '0;
      r_fixed <= 1'b0;
      r_ok    <= 1'b0;
      r_vld   <= 1'b0;
      r_last  <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      if (ar_hs) begin
        r_id    <= S_AXI_ARID;
        r_idx   <= S_AXI_ARADDR[BEAT_OFFSET +: IDX_W];
        r_left  <= {1'b0, S_AXI_ARLEN} + 9'd1;
        r_fixed <= (S_AXI_ARBURST == BURST_FIXED);
        r_ok    <= burst_supported(S_AXI_ARBURST, S_AXI_ARSIZE);
      end
      if (rd_en) begin
        r_left <= r_left - 9'd1;
        if (!r_fixed) begin
          r_idx <= r_idx + IDX_W'(1);
        end
        r_vld  <= 1'b1;
        r_last <= (r_left == 9'd1);
        r_zero <= !r_ok;
      end else if (S_AXI_RREADY) begin
        r_vld <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Shared memory
  // ---------------------------------------------------------------------
  logic              ram_we;
  logic [DATA_W-1:0] ram_q;

  // Unsupported bursts still consume their beats but never write.
  assign ram_we = w_hs && w_ok && !rst;

  sdp_ram_be #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk    (clk),
    .we     (ram_we),
    .waddr  (w_idx),
    .wbe    (S_AXI_WSTRB[STRB_W-1:0]),
    .wdata  (S_AXI_WDATA),
    .re     (rd_en && !rst),
    .raddr  (r_idx),
    .rdata  (ram_q)
  );

  // ---------------------------------------------------------------------
  // Outputs: handshakes are forced low while rst is held so an abort is
  // visible on the same cycle rather than after the next edge.
  // ---------------------------------------------------------------------
  assign S_AXI_AWREADY = aw_rdy && !rst;
  assign S_AXI_WREADY  = w_rdy && !rst;
  assign S_AXI_BVALID  = b_vld && !rst;
  assign S_AXI_BID     = w_id;
  assign S_AXI_BRESP   = (b_vld && !rst && (!w_ok || w_err)) ? RESP_SLVERR : RESP_OKAY;

  assign S_AXI_ARREADY = ar_rdy && !rst;
  assign S_AXI_RVALID  = r_vld && !rst;
  assign S_AXI_RLAST   = r_vld && r_last && !rst;
  assign S_AXI_RRESP   = (r_vld && r_zero && !rst) ? RESP_SLVERR : RESP_OKAY;
  assign S_AXI_RDATA   = (r_vld && !r_zero && !rst) ? ram_q : '0;
  assign S_AXI_RID     = r_id;

endmodule

// File: tb/tb_axi_mem_rsp.sv
// Self-checking bench for axi_mem_rsp: directed scenarios plus randomized bursts
// checked against a word-array memory model computed from the burst rules.
module tb_axi_mem_rsp;

  localparam int DATA_W = 128;
  localparam int ADDR_W = 29;
  localparam int ID_W   = 4;
  localparam int DEPTH  = 256;

  logic                clk = 1'b0;
  logic                rst;
  logic [ADDR_W-1:0]   S_AXI_AWADDR;
  logic [1:0]          S_AXI_AWBURST;
  logic [ID_W-1:0]     S_AXI_AWID;
  logic [7:0]          S_AXI_AWLEN;
  logic [2:0]          S_AXI_AWSIZE;
  logic                S_AXI_AWVALID;
  logic                S_AXI_AWREADY;
  logic [DATA_W-1:0]   S_AXI_WDATA;
  logic [DATA_W/8-1:0] S_AXI_WSTRB;
  logic                S_AXI_WLAST;
  logic                S_AXI_WVALID;
  logic                S_AXI_WREADY;
  logic [ID_W-1:0]     S_AXI_BID;
  logic [1:0]          S_AXI_BRESP;
  logic                S_AXI_BVALID;
  logic                S_AXI_BREADY;
  logic [ADDR_W-1:0]   S_AXI_ARADDR;
  logic [1:0]          S_AXI_ARBURST;
  logic [ID_W-1:0]     S_AXI_ARID;
  logic [7:0]          S_AXI_ARLEN;
  logic [2:0]          S_AXI_ARSIZE;
  logic                S_AXI_ARVALID;
  logic                S_AXI_ARREADY;
  logic [DATA_W-1:0]   S_AXI_RDATA;
  logic [ID_W-1:0]     S_AXI_RID;
  logic [1:0]          S_AXI_RRESP;
  logic                S_AXI_RLAST;
  logic                S_AXI_RVALID;
  logic                S_AXI_RREADY;

  axi_mem_rsp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .ID_W   (ID_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWBURST (S_AXI_AWBURST),
    .S_AXI_AWID    (S_AXI_AWID),
    .S_AXI_AWLEN   (S_AXI_AWLEN),
    .S_AXI_AWSIZE  (S_AXI_AWSIZE),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WLAST   (S_AXI_WLAST),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BID     (S_AXI_BID),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARBURST (S_AXI_ARBURST),
    .S_AXI_ARID    (S_AXI_ARID),
    .S_AXI_ARLEN   (S_AXI_ARLEN),
    .S_AXI_ARSIZE  (S_AXI_ARSIZE),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RID     (S_AXI_RID),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RLAST   (S_AXI_RLAST),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference memory: one entry per RAM word.
  logic [127:0] mem_m [DEPTH];
  logic [127:0] wbuf  [256];
  logic [15:0]  sbuf  [256];
  logic [127:0] rd_last_data;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit supported(input logic [1:0] burst, input logic [2:0] size);
    return ((burst == 2'b00) || (burst == 2'b01)) && (size == 3'b100);
  endfunction

  // Word touched by beat n: INCR steps one word per beat, FIXED stays put,
  // and the index aliases modulo DEPTH.
  function automatic int idx_of(input logic [28:0] addr, input logic [1:0] burst, input int beat);
    int base;
    base = int'(addr >> 4);
    return (base + ((burst == 2'b01) ? beat : 0)) % DEPTH;
  endfunction

  task automatic model_write(input int idx, input logic [127:0] d, input logic [15:0] s);
    for (int b = 0; b < 16; b++) begin
      if (s[b]) mem_m[idx][b*8 +: 8] = d[b*8 +: 8];
    end
  endtask

  // Drives one write burst from wbuf/sbuf; WLAST is placed on last_beat.
  task automatic axi_write(input logic [28:0] addr, input logic [1:0] burst, input logic [2:0] size,
                           input int len, input int last_beat, input logic [3:0] id, input int bhold);
    bit ok;
    int n;
    logic [1:0] exp_resp;
    ok = supported(burst, size);
    exp_resp = (ok && (last_beat == len)) ? 2'b00 : 2'b10;
    @(negedge clk);
    S_AXI_AWADDR  = addr;
    S_AXI_AWBURST = burst;
    S_AXI_AWSIZE  = size;
    S_AXI_AWLEN   = len[7:0];
    S_AXI_AWID    = id;
    S_AXI_AWVALID = 1'b1;
    n = 0;
    while (!S_AXI_AWREADY && n < 50) begin @(negedge clk); n++; end
    if (!S_AXI_AWREADY) begin chk("aw_timeout", 0, 1); S_AXI_AWVALID = 1'b0; return; end
    @(negedge clk);
    S_AXI_AWVALID = 1'b0;
    for (int i = 0; i <= last_beat; i++) begin
      S_AXI_WDATA  = wbuf[i];
      S_AXI_WSTRB  = sbuf[i];
      S_AXI_WLAST  = (i == last_beat);
      S_AXI_WVALID = 1'b1;
      n = 0;
      while (!S_AXI_WREADY && n < 50) begin @(negedge clk); n++; end
      if (!S_AXI_WREADY) begin chk("w_timeout", 0, 1); S_AXI_WVALID = 1'b0; return; end
      @(negedge clk);
      if (ok) model_write(idx_of(addr, burst, i), wbuf[i], sbuf[i]);
    end
    S_AXI_WVALID = 1'b0;
    S_AXI_WLAST  = 1'b0;
    n = 0;
    while (!S_AXI_BVALID && n < 50) begin @(negedge clk); n++; end
    if (!S_AXI_BVALID) begin chk("b_timeout", 0, 1); return; end
    for (int k = 0; k < bhold; k++) begin
      chk("b_held", S_AXI_BVALID, 1);
      chk("aw_rdy_in_resp", S_AXI_AWREADY, 0);
      @(negedge clk);
    end
    S_AXI_BREADY = 1'b1;
    chk("b_vld", S_AXI_BVALID, 1);
    chk("b_resp", S_AXI_BRESP, exp_resp);
    chk("b_id", S_AXI_BID, id);
    @(negedge clk);
    S_AXI_BREADY = 1'b0;
    chk("b_done_vld", S_AXI_BVALID, 0);
    chk("b_done_awrdy", S_AXI_AWREADY, 1);
    chk("b_done_wrdy", S_AXI_WREADY, 0);
  endtask

  // mode 0: RREADY always high, 1: toggles 1-0-1, 2: random.
  task automatic axi_read(input logic [28:0] addr, input logic [1:0] burst, input logic [2:0] size,
                          input int len, input logic [3:0] id, input int mode);
    bit ok, rdy, prev_hold;
    int n, beat, cyc;
    logic [127:0] prev_data, exp_d;
    logic [2:0] prev_ctl;
    ok = supported(burst, size);
    @(negedge clk);
    S_AXI_ARADDR  = addr;
    S_AXI_ARBURST = burst;
    S_AXI_ARSIZE  = size;
    S_AXI_ARLEN   = len[7:0];
    S_AXI_ARID    = id;
    S_AXI_ARVALID = 1'b1;
    n = 0;
    while (!S_AXI_ARREADY && n < 50) begin @(negedge clk); n++; end
    if (!S_AXI_ARREADY) begin chk("ar_timeout", 0, 1); S_AXI_ARVALID = 1'b0; return; end
    @(negedge clk);
    S_AXI_ARVALID = 1'b0;
    n = 0;
    while (!S_AXI_RVALID && n < 20) begin @(negedge clk); n++; end
    chk("r_latency", n, 1);
    beat = 0;
    cyc = 0;
    prev_hold = 1'b0;
    prev_data = '0;
    prev_ctl = '0;
    while (beat <= len && cyc < 4 * (len + 1) + 20) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      S_AXI_RREADY = rdy;
      if (S_AXI_RVALID) begin
        if (prev_hold) begin
          chk("r_hold_data", S_AXI_RDATA, prev_data);
          chk("r_hold_ctl", {S_AXI_RLAST, S_AXI_RRESP}, prev_ctl);
        end
        if (rdy) begin
          exp_d = ok ? mem_m[idx_of(addr, burst, beat)] : '0;
          chk("r_data", S_AXI_RDATA, exp_d);
          chk("r_resp", S_AXI_RRESP, ok ? 2'b00 : 2'b10);
          chk("r_last", S_AXI_RLAST, (beat == len));
          chk("r_id", S_AXI_RID, id);
          rd_last_data = S_AXI_RDATA;
          beat++;
        end
        prev_hold = !rdy;
        prev_data = S_AXI_RDATA;
        prev_ctl  = {S_AXI_RLAST, S_AXI_RRESP};
      end else begin
        prev_hold = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    S_AXI_RREADY = 1'b0;
    if (beat <= len) chk("r_beats", beat, len + 1);
    if (mode == 0) chk("r_thruput", cyc, len + 1);
    chk("r_done_vld", S_AXI_RVALID, 0);
    chk("r_done_arrdy", S_AXI_ARREADY, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] wrap_d [4];
    logic [28:0] a;
    logic [1:0] bt;
    int len, last, r;

    rst = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWBURST = '0; S_AXI_AWID = '0; S_AXI_AWLEN = '0;
    S_AXI_AWSIZE = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARBURST = '0; S_AXI_ARID = '0; S_AXI_ARLEN = '0;
    S_AXI_ARSIZE = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_awrdy", S_AXI_AWREADY, 0);
    chk("rst_wrdy", S_AXI_WREADY, 0);
    chk("rst_bvld", S_AXI_BVALID, 0);
    chk("rst_arrdy", S_AXI_ARREADY, 0);
    chk("rst_rvld", S_AXI_RVALID, 0);
    chk("rst_rdata", S_AXI_RDATA, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_awrdy", S_AXI_AWREADY, 1);
    chk("post_rst_arrdy", S_AXI_ARREADY, 1);

    // Write data offered with no address is not taken.
    S_AXI_WVALID = 1'b1; S_AXI_WLAST = 1'b1; S_AXI_WSTRB = '1;
    for (int k = 0; k < 3; k++) begin
      chk("idle_wrdy", S_AXI_WREADY, 0);
      @(negedge clk);
    end
    S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;

    // Single write then read
    wbuf[0] = 128'h0123456789ABCDEF0123456789ABCDEF;
    sbuf[0] = 16'hFFFF;
    axi_write(29'h40, 2'b01, 3'b100, 0, 0, 4'h5, 0);
    axi_read(29'h40, 2'b01, 3'b100, 0, 4'h9, 0);
    chk("single_rd", rd_last_data, 128'h0123456789ABCDEF0123456789ABCDEF);

    // 256-beat INCR fill, read back with RREADY toggling
    for (int i = 0; i < 256; i++) begin
      wbuf[i] = {4{32'(i)}};
      sbuf[i] = 16'hFFFF;
    end
    axi_write(29'h0, 2'b01, 3'b100, 255, 255, 4'hA, 0);
    axi_read(29'h0, 2'b01, 3'b100, 255, 4'h3, 1);

    // Partial strobe
    wbuf[0] = '1; sbuf[0] = 16'hFFFF;
    axi_write(29'h100, 2'b01, 3'b100, 0, 0, 4'h1, 0);
    wbuf[0] = '0; sbuf[0] = 16'h00FF;
    axi_write(29'h100, 2'b01, 3'b100, 0, 0, 4'h2, 0);
    axi_read(29'h100, 2'b01, 3'b100, 0, 4'h4, 0);
    chk("strobe_word", rd_last_data, {64'hFFFFFFFFFFFFFFFF, 64'h0});

    // Index wrap mid-burst with B backpressure
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
      sbuf[i] = 16'hFFFF;
      wrap_d[i] = wbuf[i];
    end
    axi_write(29'((DEPTH - 2) * 16), 2'b01, 3'b100, 3, 3, 4'h7, 10);
    axi_read(29'((DEPTH - 2) * 16), 2'b01, 3'b100, 3, 4'h7, 0);
    axi_read(29'h0, 2'b01, 3'b100, 0, 4'h8, 0);
    chk("wrap_word0", rd_last_data, wrap_d[2]);
    axi_read(29'h10, 2'b01, 3'b100, 0, 4'h8, 0);
    chk("wrap_word1", rd_last_data, wrap_d[3]);

    // Error cases
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = ~wrap_d[i];
      sbuf[i] = 16'hFFFF;
    end
    axi_write(29'h200, 2'b10, 3'b100, 3, 3, 4'hB, 0);      // WRAP: no RAM change
    axi_read(29'h200, 2'b01, 3'b100, 3, 4'hB, 2);
    axi_write(29'h300, 2'b01, 3'b100, 3, 1, 4'hC, 0);      // early WLAST
    axi_read(29'h300, 2'b01, 3'b100, 3, 4'hC, 2);
    axi_write(29'h400, 2'b01, 3'b011, 1, 1, 4'hD, 0);      // narrow size
    axi_read(29'h400, 2'b01, 3'b100, 1, 4'hD, 0);
    axi_read(29'h200, 2'b10, 3'b100, 3, 4'hE, 0);          // WRAP read: zeros, SLVERR

    // Reset in the middle of a 16-beat write
    @(negedge clk);
    S_AXI_AWADDR = 29'h800; S_AXI_AWBURST = 2'b01; S_AXI_AWSIZE = 3'b100;
    S_AXI_AWLEN = 8'd15; S_AXI_AWID = 4'h6; S_AXI_AWVALID = 1'b1;
    @(negedge clk);
    chk("rstb_aw_taken", S_AXI_AWREADY, 0);
    S_AXI_AWVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wbuf[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
      S_AXI_WDATA = wbuf[i]; S_AXI_WSTRB = 16'hFFFF; S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b1;
      chk("rstb_wrdy", S_AXI_WREADY, 1);
      @(negedge clk);
      model_write(idx_of(29'h800, 2'b01, i), wbuf[i], 16'hFFFF);
    end
    S_AXI_WDATA = ~wbuf[0];
    rst = 1'b1;
    @(negedge clk);
    S_AXI_WVALID = 1'b0;
    chk("rstb_bvld_in_rst", S_AXI_BVALID, 0);
    chk("rstb_awrdy_in_rst", S_AXI_AWREADY, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rstb_awrdy_after", S_AXI_AWREADY, 1);
    for (int k = 0; k < 4; k++) begin
      chk("rstb_no_bvld", S_AXI_BVALID, 0);
      @(negedge clk);
    end
    wbuf[0] = {4{32'hC0FFEE00}}; sbuf[0] = 16'hFFFF;
    axi_write(29'h900, 2'b01, 3'b100, 0, 0, 4'hF, 0);
    axi_read(29'h800, 2'b01, 3'b100, 6, 4'h1, 0);

    // Randomized bursts against the model
    for (int t = 0; t < 30; t++) begin
      a = 29'($urandom());
      r = $urandom_range(0, 9);
      bt = (r < 6) ? 2'b01 : ((r < 9) ? 2'b00 : 2'b10);
      len = $urandom_range(0, 15);
      last = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len) : len;
      for (int i = 0; i <= len; i++) begin
        wbuf[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        sbuf[i] = 16'($urandom());
      end
      axi_write(a, bt, 3'b100, len, last, 4'($urandom()), $urandom_range(0, 3));
      a = ($urandom_range(0, 1) == 0) ? a : 29'($urandom());
      r = $urandom_range(0, 9);
      bt = (r < 6) ? 2'b01 : ((r < 9) ? 2'b00 : 2'b10);
      axi_read(a, bt, 3'b100, $urandom_range(0, 15), 4'($urandom()), 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/axi_mem_rsp.md
Name: axi_mem_rsp

Overview:
- AXI4 responder (slave) backed by on-chip memory.
- Answers the write path (AW/W/B) and read path (AR/R) driven by the existing HBM/DDR initiator wrappers, so write/read traffic can be exercised and checked without the memory controller.
- Independent write and read engines share one simple-dual-port RAM.
- AxCACHE/AxLOCK/AxPROT/AxQOS from the initiator are left unconnected.

Parameters:
- DATA_W, 128, data bus width; the byte-strobe width is DATA_W/8.
- ADDR_W, 29, byte address width.
- ID_W, 4, transaction ID width.
- DEPTH, 1024, RAM depth in DATA_W words; must be a power of two.

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous reset, active-high.
- S_AXI_AWADDR  in  ADDR_W  write burst start byte address.
- S_AXI_AWBURST  in  2  burst type.
- S_AXI_AWID  in  ID_W  write ID.
- S_AXI_AWLEN  in  8  beats minus 1.
- S_AXI_AWSIZE  in  3  beat size.
- S_AXI_AWVALID  in  1 / S_AXI_AWREADY  out  1  AW handshake.
- S_AXI_WDATA  in  DATA_W  write data.
- S_AXI_WSTRB  in  DATA_W/8  byte enables.
- S_AXI_WLAST  in  1  last write beat.
- S_AXI_WVALID  in  1 / S_AXI_WREADY  out  1  W handshake.
- S_AXI_BID  out  ID_W  echoed AWID.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID  out  1 / S_AXI_BREADY  in  1  B handshake.
- S_AXI_ARADDR  in  ADDR_W / S_AXI_ARBURST  in  2 / S_AXI_ARID  in  ID_W / S_AXI_ARLEN  in  8 / S_AXI_ARSIZE  in  3  read request fields.
- S_AXI_ARVALID  in  1 / S_AXI_ARREADY  out  1  AR handshake.
- S_AXI_RDATA  out  DATA_W  read data.
- S_AXI_RID  out  ID_W  echoed ARID.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RLAST  out  1  last read beat.
- S_AXI_RVALID  out  1 / S_AXI_RREADY  in  1  R handshake.

Behaviour:
- Reset (synchronous, active-high): all outputs 0, both FSMs to IDLE. RAM contents are not cleared. AWREADY/ARREADY rise the first cycle after rst deasserts.
- Word index = addr[4+log2(DEPTH)-1:4]. Addresses alias modulo DEPTH, and the index wraps DEPTH-1 -> 0 mid-burst. Low 4 address bits are ignored.
- A burst is supported when burst = INCR (01) or FIXED (00) and size = 3'b100. INCR increments the word index per beat; FIXED holds it. Anything else is unsupported.
- Write FSM W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: AWREADY=1, WREADY=0. On the AW handshake, capture ID, index, len, burst and a support flag, then go to W_DATA.
  - W_DATA: AWREADY=0, WREADY=1. Each W handshake writes the RAM with WSTRB byte enables (suppressed if unsupported) and increments the beat counter.
  - Error flag is set if WLAST arrives before beat len, or is absent on beat len. The burst always ends on the WLAST beat.
  - On WLAST, go to W_RESP.
  - W_RESP: BVALID=1, BID=captured ID, BRESP=SLVERR (10) if unsupported or error flag set, else OKAY (00). Hold until BREADY, then return to W_IDLE.
  - W beats presented while in W_IDLE are not accepted (no write-data-before-address).
- Read FSM R_IDLE -> R_DATA:
  - R_IDLE: ARREADY=1. On the AR handshake, capture fields, go to R_DATA.
  - R_DATA: RAM read issued whenever beats remain and (!RVALID || RREADY). The registered RAM output drives RDATA, with RVALID asserted the cycle after the read.
  - Latency: AR handshake at cycle T, first RVALID at T+2. Full throughput afterwards: one beat per cycle when RREADY is held high.
  - RLAST=1 on beat len. RID = captured ARID.
  - Unsupported burst: len+1 beats of RDATA=0 with RRESP=SLVERR; otherwise RRESP=OKAY.
  - After the RLAST handshake, return to R_IDLE. ARREADY stays 0 during R_DATA.
- RDATA, RLAST, RRESP and RVALID hold stable while RVALID && !RREADY.
- Same-cycle read and write of the same word: the read returns the old data (read-first).
- rst mid-burst aborts both engines immediately: no B response, no further R beats; a partially written burst remains in RAM.
- Write and read engines run concurrently with no ordering between them.

Decomposition:
- Shared package axi_pkg:
  - BURST_FIXED=2'b00, BURST_INCR=2'b01, BURST_WRAP=2'b10.
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - SIZE_16B=3'b100.
  - Write-FSM and read-FSM state enums.
- One sub-module: sdp_ram_be, a simple-dual-port RAM of DEPTH x DATA_W with a byte-enable write port, a synchronous read port with read enable, and read-first behaviour.

Test Plan:
- Single write: AW addr=0x40, len=0, INCR, size=4, WDATA=0x0123..EF, WSTRB=0xFFFF -> BRESP=00, BID=AWID. A read of 0x40 then returns the same data with RLAST=1, RVALID at T+2.
- 256-beat INCR write of an incrementing pattern from addr 0, then read back with RREADY toggling 1-0-1 -> all 256 beats match in order, RLAST only on beat 255, no dropped or duplicated beats.
- Partial strobe: word at 0x100 preloaded 0xFF..FF, write WSTRB=0x00FF data 0 -> read returns upper 8 bytes 0xFF, lower 8 bytes 0x00.
- Wrap and backpressure: INCR len=3 starting at word DEPTH-2 -> data lands in words DEPTH-2, DEPTH-1, 0, 1. Hold BREADY=0 for 10 cycles -> BVALID held, AWREADY=0 throughout.
- Error cases, each -> BRESP=10:
  - AW burst=WRAP, len=3 -> RAM unchanged.
  - WLAST on beat 1 of len=3 -> RAM written for beats 0-1 only.
  - AR burst=WRAP -> 4 beats of zeros with RRESP=10.
- Reset mid-burst: assert rst at write beat 5 of len=15 -> BVALID never rises, AWREADY=1 the cycle after rst drops, and a new single-beat write completes OKAY.
